// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: FSM states, ALU op codes and op-code legality check shared by the arbiter
package alu_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
  endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not granted last wins
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = (&valid) ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters, one transaction in flight
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [3:0]       ALU_ctrl,
  output logic [WIDTH-1:0] ALU_operand_1,
  output logic [WIDTH-1:0] ALU_operand_2,
  input  logic [WIDTH-1:0] ALU_result
);
  state_t state;
  logic last;
  logic [1:0] grant;
  logic xfer;
  logic legal;
  logic [WIDTH-1:0] result;
  rr_arb2 u_arb (
    .valid(req_valid),
    .last (last),
    .grant(grant)
  );
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign xfer = |(req_valid & req_ready);
  assign legal = is_legal_op(ALU_ctrl);
  assign result = legal ? ALU_result : '0;
  // ALU_* double as the latched request, so they hold their values outside EXEC;
  // last always names the requester of the transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      ALU_ctrl      <= '0;
      ALU_operand_1 <= '0;
      ALU_operand_2 <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          last          <= req_ready[1];
          ALU_ctrl      <= req_ready[1] ? req1_ctrl : req0_ctrl;
          ALU_operand_1 <= req_ready[1] ? req1_op1 : req0_op1;
          ALU_operand_2 <= req_ready[1] ? req1_op2 : req0_op2;
          state         <= EXEC;
        end
        EXEC: begin
          rsp_result <= result;
          rsp_zero   <= ~|result;
          rsp_err    <= ~legal;
          rsp_id     <= last;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors, hand-written corner sequences and a randomized run against a transaction-level model
module tb_alu_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic rsp_ready = 1'b0;
  logic [W-1:0] rsp_result, ALU_operand_1, ALU_operand_2, ALU_result;
  logic [3:0] ALU_ctrl;
  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .ALU_ctrl(ALU_ctrl),
    .ALU_operand_1(ALU_operand_1), .ALU_operand_2(ALU_operand_2), .ALU_result(ALU_result)
  );

  always #5 clk = ~clk;

  // shared ALU; illegal codes return junk the arbiter must not pass through
  always_comb begin
    case (ALU_ctrl)
      4'b0000: ALU_result = ALU_operand_1 & ALU_operand_2;
      4'b0001: ALU_result = ALU_operand_1 | ALU_operand_2;
      4'b0010: ALU_result = ALU_operand_1 + ALU_operand_2;
      4'b0110: ALU_result = ALU_operand_1 - ALU_operand_2;
      4'b0111: ALU_result = (ALU_operand_1 < ALU_operand_2) ? 32'd1 : 32'd0;
      4'b1100: ALU_result = ~(ALU_operand_1 | ALU_operand_2);
      default: ALU_result = 32'hDEADBEEF;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int r;
    logic [3:0] c;
    logic [31:0] a, b, res;
    logic z, e;
  } tv_t;

  function automatic logic [32:0] ref_rsp(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'b1100: return {1'b0, ~(a | b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_ready"}, 32'(req_ready), 32'd0);
    check({p, "_valid"}, 32'(rsp_valid), 32'd0);
    check({p, "_id"}, 32'(rsp_id), 32'd0);
    check({p, "_result"}, rsp_result, 32'd0);
    check({p, "_zero"}, 32'(rsp_zero), 32'd0);
    check({p, "_err"}, 32'(rsp_err), 32'd0);
    check({p, "_ctrl"}, 32'(ALU_ctrl), 32'd0);
    check({p, "_op1"}, ALU_operand_1, 32'd0);
    check({p, "_op2"}, ALU_operand_2, 32'd0);
  endtask

  task automatic set_req(input int r, input logic [3:0] c, input logic [31:0] a, b);
    if (r == 0) begin
      req0_ctrl = c; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_ctrl = c; req1_op1 = a; req1_op2 = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // starts and ends just after a rising edge with the arbiter idle
  task automatic single(input tv_t v, input int k);
    int t;
    t = 0;
    set_req(v.r, v.c, v.a, v.b);
    req_valid = (v.r != 0) ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (!req_ready[v.r] && t < 8) begin
      @(posedge clk); #1; @(negedge clk);
      t++;
    end
    check($sformatf("tv%0d_grant", k), 32'(req_ready), (v.r != 0) ? 32'd2 : 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check($sformatf("tv%0d_t1_valid", k), 32'(rsp_valid), 32'd0);
    @(posedge clk); #1; @(negedge clk);
    check($sformatf("tv%0d_t2_valid", k), 32'(rsp_valid), 32'd1);
    check($sformatf("tv%0d_id", k), 32'(rsp_id), 32'(v.r));
    check($sformatf("tv%0d_result", k), rsp_result, v.res);
    check($sformatf("tv%0d_zero", k), 32'(rsp_zero), 32'(v.z));
    check($sformatf("tv%0d_err", k), 32'(rsp_err), 32'(v.e));
    @(posedge clk); #1;
  endtask

  tv_t tv[12];
  logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};

  function automatic logic [3:0] pick_ctrl();
    return ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
  endfunction

  function automatic logic [31:0] pick_op();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
  endfunction

  initial begin
    int g[4];
    int ng, nr, nh;
    logic [1:0] exp_rdy;
    logic exp_v, busy, last, m_id, m_z, m_e;
    logic [3:0] m_c;
    logic [31:0] m_a, m_b, m_r;
    logic [32:0] rr;
    int t_x;
    tv[0]  = '{0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    tv[1]  = '{1, 4'b1111, 32'd10, 32'd20, 32'd0, 1'b1, 1'b1};
    tv[2]  = '{0, 4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[3]  = '{1, 4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0};
    tv[4]  = '{0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
    tv[5]  = '{1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0};
    tv[6]  = '{0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0};
    tv[7]  = '{1, 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0};
    tv[8]  = '{0, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0};
    tv[9]  = '{0, 4'b0011, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1};
    tv[10] = '{1, 4'b0110, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0};
    tv[11] = '{1, 4'b1100, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 1'b1, 1'b0};

    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #2 check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 2'b00;

    for (int k = 0; k < 12; k++) single(tv[k], k);

    // both requesters valid continuously: grants must alternate starting from 0
    do_reset();
    set_req(0, 4'b0110, 32'd9, 32'd9);
    set_req(1, 4'b0111, 32'd3, 32'd9);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (|req_ready && ng < 4) begin
        g[ng] = int'(req_ready[1]);
        ng++;
      end
      if (rsp_valid) begin
        nr++;
        check($sformatf("alt_rsp%0d_result", nr), rsp_result, rsp_id ? 32'd1 : 32'd0);
        check($sformatf("alt_rsp%0d_zero", nr), 32'(rsp_zero), rsp_id ? 32'd0 : 32'd1);
        check($sformatf("alt_rsp%0d_id", nr), 32'(rsp_id), 32'((nr - 1) % 2));
      end
      @(posedge clk);
      #1 if (ng >= 4) req_valid = 2'b00;
    end
    check("alt_ngrant", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("alt_grant%0d", i), 32'(g[i]), 32'(i % 2));
    check("alt_nrsp", 32'(nr), 32'd4);

    // back-pressure: response held for 5 cycles with both requesters knocking
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b0010, 32'd4, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1; @(negedge clk);
    check("stall_exec_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; @(negedge clk);
      check($sformatf("stall%0d_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_fields", i), {rsp_id, rsp_zero, rsp_err, rsp_result[28:0]}, 32'd3);
      check($sformatf("stall%0d_result", i), rsp_result, 32'd3);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    req_valid = 2'b00;
    nh = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) nh++;
      @(posedge clk); #1;
    end
    check("stall_nresp", 32'(nh), 32'd1);

    // reset while a transaction is in EXEC
    set_req(1, 4'b0010, 32'd2, 32'd3);
    req_valid = 2'b10;
    @(negedge clk);
    check("rexec_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid = 2'b11;
    rst_n = 1'b0;
    #1 check_zero("rexec");
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rexec_quiet%0d", i), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 2'b11;
    @(negedge clk);
    check("rexec_first_tie", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // randomized traffic against a transaction-level model
    do_reset();
    busy = 1'b0;
    last = 1'b1;
    t_x = 0;
    m_id = 1'b0; m_c = '0; m_a = '0; m_b = '0; m_r = '0; m_z = 1'b0; m_e = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 req_valid = 2'($urandom_range(0, 3));
      req0_ctrl = pick_ctrl(); req0_op1 = pick_op(); req0_op2 = pick_op();
      req1_ctrl = pick_ctrl(); req1_op1 = pick_op(); req1_op2 = pick_op();
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = busy ? 2'b00 : (&req_valid) ? (last ? 2'b01 : 2'b10) : req_valid;
      exp_v = busy && (c >= t_x + 2);
      check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_valid", 32'(rsp_valid), 32'(exp_v));
      if (busy) begin
        check("rnd_alu_ctrl", 32'(ALU_ctrl), 32'(m_c));
        check("rnd_alu_op1", ALU_operand_1, m_a);
        check("rnd_alu_op2", ALU_operand_2, m_b);
      end
      if (exp_v) begin
        check("rnd_id", 32'(rsp_id), 32'(m_id));
        check("rnd_result", rsp_result, m_r);
        check("rnd_zero_err", {30'd0, rsp_zero, rsp_err}, {30'd0, m_z, m_e});
        if (rsp_ready) busy = 1'b0;
      end else if (!busy && |(req_valid & exp_rdy)) begin
        m_id = exp_rdy[1];
        last = m_id;
        m_c = m_id ? req1_ctrl : req0_ctrl;
        m_a = m_id ? req1_op1 : req0_op1;
        m_b = m_id ? req1_op2 : req0_op2;
        rr = ref_rsp(m_c, m_a, m_b);
        m_e = rr[32];
        m_r = rr[31:0];
        m_z = (m_r == 32'd0);
        busy = 1'b1;
        t_x = c;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
